fifo_burst_scheduler: RTL and testbench
=======================================

# fifo_burst_scheduler

Packet-atomic round-robin scheduler that shares one downstream StreamingFIFO write port among N_REQ AXI-Stream producers. Admits a fixed-length burst from a requester only when the FIFO's reported occupancy leaves room for the whole burst. Once admitted, holds the grant until all BURST beats have been accepted. Sits directly in front of the shared FIFO's `in0_V_V_*` port and reads back its `count` output.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 512: stream data width in bits.
- `DEPTH`, 16384: capacity of the downstream FIFO in beats.
- `COUNT_W`, 15: width of `fifo_count`; must satisfy 2^COUNT_W > DEPTH.
- `BURST`, 64: beats per packet, 1..DEPTH.

Ports:
- `ap_clk`, in, 1: single clock; all logic is rising-edge.
- `ap_rst`, in, 1: synchronous, active-high reset.
- `in_V_V_TDATA`, in, N_REQ*WIDTH: requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- `in_V_V_TVALID`, in, N_REQ: per-requester valid.
- `in_V_V_TREADY`, out, N_REQ: per-requester ready.
- `out_V_V_TDATA`, out, WIDTH: data to the FIFO write port.
- `out_V_V_TVALID`, out, 1: valid to the FIFO.
- `out_V_V_TREADY`, in, 1: ready from the FIFO.
- `fifo_count`, in, COUNT_W: current FIFO occupancy, registered in the FIFO.
- `grant`, out, N_REQ: one-hot grant; 0 when idle.
- `busy`, out, 1: high while in BURST.
- `stall_cycles`, out, 32: saturating count of cycles spent waiting for space.

## Operation
- FSM states:
  - IDLE: `grant`=0, `busy`=0, all TREADY=0, `out_V_V_TVALID`=0.
  - BURST: `grant` is one-hot, `busy`=1.
- Free space: `free = DEPTH - fifo_count`, computed at COUNT_W+1 bits. If `fifo_count > DEPTH`, free is forced to 0.
- IDLE -> BURST when `|in_V_V_TVALID` and `free >= BURST`.
  - Winner is the first valid requester searched from `last+1` upward, wrapping modulo N_REQ.
  - `last` <= winner; `grant` <= onehot(winner); beat counter <= 0.
- IDLE with `|in_V_V_TVALID` and `free < BURST`: stay in IDLE; `stall_cycles` += 1, saturating at 0xFFFF_FFFF.
- In BURST, the datapath is combinational, with no register stage:
  - `out_V_V_TDATA` = slice[g]
  - `out_V_V_TVALID` = `in_V_V_TVALID[g]`
  - `in_V_V_TREADY[i]` = (i==g) & `out_V_V_TREADY`
- Beat counter increments on each out handshake. On the handshake where the counter equals BURST-1: BURST -> IDLE, `grant` <= 0.
- A granted requester that drops TVALID mid-burst keeps the grant. The result is bubbles only; there is no timeout and no preemption.
- Non-granted requesters see TREADY=0 at all times; their data is never forwarded.
- Only requesters with TVALID high at the IDLE decision cycle are considered.
- Reset values:
  - state IDLE; `grant` 0; `busy` 0; beat counter 0; `stall_cycles` 0.
  - `last` = N_REQ-1, so requester 0 has first priority.
  - All TREADY and `out_V_V_TVALID` are 0.
- Reset mid-burst aborts the burst immediately. The partial packet already written to the FIFO stays there; cleaning it up is the system's responsibility.

## Timing
- Decision latency: TVALID seen in IDLE at cycle t with space available -> `grant`/`busy` high at t+1 -> first beat can transfer at t+1.
- Peak throughput: BURST beats per BURST+1 cycles. The mandatory one-cycle IDLE gap between bursts lets `fifo_count` reflect the last written beat before the next admission check.
- Space check happens only in IDLE. During BURST, `fifo_count` is ignored; admission already guaranteed room.
- Combinational paths are TVALID->TVALID, TREADY->TREADY and TDATA->TDATA through an N_REQ:1 mux. The integrator registers them externally if timing requires.

## Structure
- Package `fifo_sched_pkg` holds:
  - the state enum {IDLE, BURST};
  - `IDX_W = $clog2(N_REQ)` and `BEAT_W = $clog2(BURST)` helper functions;
  - the 32-bit saturation constant.
- Sub-module `rr_arbiter` is a combinational rotating-priority picker.
  - Inputs: `req[N_REQ]`, `last`.
  - Outputs: `found`, `idx`.
  - Verified standalone exhaustively for N_REQ=4.
- Top level holds the FSM, beat counter, `last` register, stall counter and data mux.

## Test plan
- Single requester 0, `fifo_count`=0, BURST=64, `out_V_V_TREADY`=1 -> `grant`=0001 one cycle after TVALID; 64 beats in 64 consecutive cycles; then one IDLE cycle.
- All four requesters continuously valid -> grant order 0,1,2,3,0; every burst is exactly 64 beats; no interleaving of requesters' data.
- `fifo_count`=16321 (free 63) with requester 2 valid -> stays IDLE; `stall_cycles` increments each cycle. Set `fifo_count`=16320 (free 64) -> grant 0100 next cycle.
- Granted requester drops TVALID for 5 cycles at beat 10 -> `out_V_V_TVALID`=0 for those cycles, `grant` held, total beats still 64. Same check with `out_V_V_TREADY` low for 5 cycles: no beat lost or duplicated.
- `ap_rst` asserted at beat 30 -> next cycle `grant`=0, `busy`=0, all TREADY=0. After release, requesters 0 and 3 both valid -> requester 0 wins.
- `fifo_count`=20000 (> DEPTH) -> treated as free 0; never grants. Force `stall_cycles` to 0xFFFF_FFFE, then wait 3 cycles -> reads 0xFFFF_FFFF.

Source files
------------

// File: rtl/fifo_burst_scheduler_pkg.sv
// rtl/fifo_burst_scheduler_pkg.sv - shared types, widths and constants for fifo_burst_scheduler
package fifo_sched_pkg;

   typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

   localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

   function automatic int idx_w(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

   // A one-beat burst still needs a 1-bit counter to keep the ports legal
   function automatic int beat_w(input int burst);
      return (burst > 1) ? $clog2(burst) : 1;
   endfunction

endpackage

// File: rtl/fifo_burst_scheduler_arb.sv
// rtl/fifo_burst_scheduler_arb.sv - combinational rotating-priority picker starting after last
module rr_arbiter
   import fifo_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = idx_w(N_REQ)
)(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   function automatic logic [IDX_W-1:0] wrap(input int p);
      return IDX_W'(p % N_REQ);
   endfunction

   always_comb begin
      found = 1'b0;
      idx   = last;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!found && req[wrap(int'(last) + k)]) begin
            found = 1'b1;
            idx   = wrap(int'(last) + k);
         end
      end
   end

endmodule

// File: rtl/fifo_burst_scheduler.sv
// rtl/fifo_burst_scheduler.sv - packet-atomic round-robin admission of fixed bursts into a shared FIFO
module fifo_burst_scheduler
   import fifo_sched_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = 512,
   parameter int DEPTH   = 16384,
   parameter int COUNT_W = 15,
   parameter int BURST   = 64
)(
   input  logic                   ap_clk,
   input  logic                   ap_rst,
   input  logic [N_REQ*WIDTH-1:0] in_V_V_TDATA,
   input  logic [N_REQ-1:0]       in_V_V_TVALID,
   output logic [N_REQ-1:0]       in_V_V_TREADY,
   output logic [WIDTH-1:0]       out_V_V_TDATA,
   output logic                   out_V_V_TVALID,
   input  logic                   out_V_V_TREADY,
   input  logic [COUNT_W-1:0]     fifo_count,
   output logic [N_REQ-1:0]       grant,
   output logic                   busy,
   output logic [31:0]            stall_cycles
);

   localparam int                IDX_W     = idx_w(N_REQ);
   localparam int                BEAT_W    = beat_w(BURST);
   localparam logic [COUNT_W:0]  DEPTH_C   = (COUNT_W+1)'(DEPTH);
   localparam logic [COUNT_W:0]  BURST_C   = (COUNT_W+1)'(BURST);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST-1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [31:0]       stall_q, stall_d;
   logic [COUNT_W:0]  free;
   logic              found;
   logic [IDX_W-1:0]  win;
   logic              out_hs;

   rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
      .req   (in_V_V_TVALID),
      .last  (last_q),
      .found (found),
      .idx   (win)
   );

   // An over-range count means the FIFO is misreporting; never admit against it
   assign free = ({1'b0, fifo_count} > DEPTH_C) ? '0 : DEPTH_C - {1'b0, fifo_count};

   assign busy         = (state_q == ST_BURST);
   assign grant        = grant_q;
   assign stall_cycles = stall_q;

   // last_q names the owner for the whole burst, so it doubles as the mux select
   assign out_V_V_TDATA  = in_V_V_TDATA[last_q*WIDTH +: WIDTH];
   assign out_V_V_TVALID = busy & in_V_V_TVALID[last_q];
   assign in_V_V_TREADY  = grant_q & {N_REQ{out_V_V_TREADY}};
   assign out_hs         = out_V_V_TVALID & out_V_V_TREADY;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      beat_d  = beat_q;
      stall_d = stall_q;
      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               if (free >= BURST_C) begin
                  state_d = ST_BURST;
                  last_d  = win;
                  grant_d = N_REQ'(1) << win;
                  beat_d  = '0;
               end else if (stall_q != STALL_MAX) begin
                  stall_d = stall_q + 32'd1;
               end
            end
         end
         ST_BURST: begin
            if (out_hs) begin
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= ST_IDLE;
         last_q  <= IDX_W'(N_REQ-1);
         grant_q <= '0;
         beat_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         beat_q  <= beat_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// tb/tb_fifo_burst_scheduler.sv - directed and randomized checks of fifo_burst_scheduler against a cycle model
module tb_fifo_burst_scheduler;

   localparam int N = 4, W = 512, DEPTH = 16384, CW = 15, BURST = 64, IW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N*W-1:0] tdata;
   logic [N-1:0]  tvalid = '0;
   logic [N-1:0]  tready;
   logic [W-1:0]  odata;
   logic          ovalid;
   logic          ordy = 1'b0;
   logic [CW-1:0] fcount = '0;
   logic [N-1:0]  grant;
   logic          busy;
   logic [31:0]   stall;
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   fifo_burst_scheduler #(.N_REQ(N), .WIDTH(W), .DEPTH(DEPTH), .COUNT_W(CW), .BURST(BURST)) dut (
      .ap_clk(clk), .ap_rst(rst),
      .in_V_V_TDATA(tdata), .in_V_V_TVALID(tvalid), .in_V_V_TREADY(tready),
      .out_V_V_TDATA(odata), .out_V_V_TVALID(ovalid), .out_V_V_TREADY(ordy),
      .fifo_count(fcount), .grant(grant), .busy(busy), .stall_cycles(stall)
   );

   // Reference model: owner index (-1 idle), beats sent, round-robin pointer, stall count,
   // and per-requester sequence numbers that tag the data each source presents.
   int          m_owner = -1;
   int          m_beats = 0;
   int          m_last  = N-1;
   logic [31:0] m_stall = '0;
   int          seq [N];
   int          m_pick;

   function automatic logic [W-1:0] beat_data(input int r, input int s);
      logic [31:0] w;
      w = {r[7:0], s[23:0]};
      return {16{w}};
   endfunction

   function automatic int pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[IW'((last + k) % N)]) return (last + k) % N;
      return -1;
   endfunction

   function automatic int free_of(input logic [CW-1:0] c);
      return (int'(c) > DEPTH) ? 0 : DEPTH - int'(c);
   endfunction

   always_comb begin
      for (int i = 0; i < N; i++) tdata[i*W +: W] = beat_data(i, seq[i]);
   end

   always_comb m_pick = pick(tvalid, m_last);

   always @(posedge clk) begin
      if (m_owner >= 0 && tvalid[IW'(m_owner)] && ordy) seq[m_owner] <= seq[m_owner] + 1;
      if (rst) begin
         m_owner <= -1;
         m_beats <= 0;
         m_last  <= N-1;
         m_stall <= '0;
      end else if (m_owner < 0) begin
         if (m_pick >= 0) begin
            if (free_of(fcount) >= BURST) begin
               m_owner <= m_pick;
               m_last  <= m_pick;
               m_beats <= 0;
            end else if (m_stall != 32'hFFFF_FFFF) begin
               m_stall <= m_stall + 32'd1;
            end
         end
      end else if (tvalid[IW'(m_owner)] && ordy) begin
         if (m_beats == BURST-1) m_owner <= -1;
         m_beats <= m_beats + 1;
      end
   end

   logic [N-1:0] exp_grant, exp_tready;
   logic         exp_busy, exp_ov;
   logic [W-1:0] exp_data;

   always_comb begin
      exp_grant  = '0;
      exp_tready = '0;
      exp_busy   = 1'b0;
      exp_ov     = 1'b0;
      exp_data   = '0;
      if (m_owner >= 0) begin
         exp_grant  = N'(1) << m_owner;
         exp_busy   = 1'b1;
         exp_ov     = tvalid[IW'(m_owner)];
         exp_tready = ordy ? exp_grant : '0;
         exp_data   = beat_data(m_owner, seq[m_owner]);
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      tvalid = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tvalid = '1; ordy = 1'b1; fcount = '0;
      repeat (2) @(negedge clk);
      #1;
      total++; if (grant !== '0) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (tready !== '0) begin bad++; $display("FAIL reset_tready got=%b want=0000", tready); end
      total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%b want=0", ovalid); end
      total++; if (stall !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall); end
      @(negedge clk);
      rst = 1'b0; tvalid = '0;
   endtask

   task automatic test_single();
      int hs;
      hs = 0;
      do_reset();
      fcount = '0; ordy = 1'b1; tvalid = 4'b0001;
      #1;
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_decision got=%b want=0000", grant); end
      for (int c = 1; c <= BURST; c++) begin
         @(negedge clk); #1;
         total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant c=%0d got=%b want=0001", c, grant); end
         total++; if (odata !== exp_data) begin bad++; $display("FAIL single_data c=%0d got=%h want=%h", c, odata[31:0], exp_data[31:0]); end
         if (ovalid && ordy) hs++;
      end
      @(negedge clk);
      tvalid = '0;
      #1;
      total++; if (grant !== '0 || busy !== 1'b0) begin bad++; $display("FAIL single_gap got grant=%b busy=%b want 0000/0", grant, busy); end
      total++; if (hs != BURST) begin bad++; $display("FAIL single_beats got=%0d want=%0d", hs, BURST); end
   endtask

   task automatic test_round_robin();
      int order[$];
      int beats[$];
      logic [N-1:0] prev;
      int gi;
      prev = '0;
      do_reset();
      fcount = '0; ordy = 1'b1; tvalid = '1;
      for (int c = 0; c <= 5*(BURST+1); c++) begin
         if (c == 5*(BURST+1)) tvalid = '0;
         #1;
         total++; if (grant !== exp_grant) begin bad++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, grant, exp_grant); end
         if (exp_ov) begin
            total++; if (odata !== exp_data) begin bad++; $display("FAIL rr_data c=%0d got=%h want=%h", c, odata[31:0], exp_data[31:0]); end
         end
         if (grant !== '0 && prev === '0) begin
            gi = -1;
            for (int i = 0; i < N; i++) if (grant[i]) gi = i;
            order.push_back(gi);
            beats.push_back(0);
         end
         if (ovalid && ordy && beats.size() > 0) beats[beats.size()-1]++;
         prev = grant;
         @(negedge clk);
      end
      total++; if (order.size() != 5) begin bad++; $display("FAIL rr_count got=%0d want=5", order.size()); end
      for (int i = 0; i < 5 && i < order.size(); i++) begin
         total++; if (order[i] != i % N) begin bad++; $display("FAIL rr_order i=%0d got=%0d want=%0d", i, order[i], i % N); end
         total++; if (beats[i] != BURST) begin bad++; $display("FAIL rr_len i=%0d got=%0d want=%0d", i, beats[i], BURST); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      ordy = 1'b1; fcount = CW'(16321); tvalid = 4'b0100;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++; if (grant !== '0 || stall !== 32'(k)) begin bad++; $display("FAIL stall_wait k=%0d got grant=%b stall=%0d want 0000/%0d", k, grant, stall, k); end
         @(negedge clk);
      end
      fcount = CW'(16320);
      #1;
      total++; if (stall !== 32'd5) begin bad++; $display("FAIL stall_count got=%0d want=5", stall); end
      @(negedge clk); #1;
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL stall_admit got=%b want=0100", grant); end
   endtask

   task automatic test_bubbles();
      int hs, hold;
      logic pause;
      logic [N-1:0] me;
      for (int m = 0; m < 2; m++) begin
         me = (m == 0) ? 4'b0001 : 4'b0010;
         hs = 0; hold = 0;
         do_reset();
         fcount = '0;
         for (int c = 0; c < 80; c++) begin
            tvalid = (hs < BURST) ? me : '0;
            ordy = 1'b1;
            pause = (hs == 10 && hold < 5);
            if (pause) begin
               hold++;
               if (m == 0) tvalid = '0; else ordy = 1'b0;
            end
            #1;
            if (pause) begin
               total++; if (grant !== me || (ovalid && ordy)) begin bad++; $display("FAIL bubble_hold m=%0d got grant=%b ov=%b rdy=%b want %b/no beat", m, grant, ovalid, ordy, me); end
            end
            total++; if (tready !== exp_tready) begin bad++; $display("FAIL bubble_tready m=%0d c=%0d got=%b want=%b", m, c, tready, exp_tready); end
            if (ovalid && ordy) begin
               total++; if (odata !== exp_data) begin bad++; $display("FAIL bubble_data m=%0d c=%0d got=%h want=%h", m, c, odata[31:0], exp_data[31:0]); end
               hs++;
            end
            @(negedge clk);
         end
         total++; if (hs != BURST || grant !== '0) begin bad++; $display("FAIL bubble_total m=%0d got beats=%0d grant=%b want %0d/0000", m, hs, grant, BURST); end
      end
   endtask

   task automatic test_reset_mid();
      int hs;
      hs = 0;
      do_reset();
      fcount = '0; ordy = 1'b1; tvalid = 4'b0010;
      for (int c = 0; c < 60 && hs < 30; c++) begin
         #1;
         if (ovalid && ordy) hs++;
         @(negedge clk);
      end
      total++; if (hs != 30) begin bad++; $display("FAIL rstmid_reach got=%0d want=30", hs); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; tvalid = 4'b1001;
      #1;
      total++; if (grant !== '0 || busy !== 1'b0 || tready !== '0) begin bad++; $display("FAIL rstmid_abort got grant=%b busy=%b tready=%b want 0000/0/0000", grant, busy, tready); end
      @(negedge clk); #1;
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rstmid_prio got=%b want=0001", grant); end
   endtask

   task automatic test_overflow_sat();
      do_reset();
      fcount = CW'(20000); tvalid = '1; ordy = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1;
         total++; if (grant !== '0) begin bad++; $display("FAIL ovf_grant k=%0d got=%b want=0000", k, grant); end
         @(negedge clk);
      end
      #1;
      total++; if (stall !== 32'd10) begin bad++; $display("FAIL ovf_stall got=%0d want=10", stall); end
      force dut.stall_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_q;
      @(negedge clk); #1;
      total++; if (stall !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_step got=%h want=ffffffff", stall); end
      repeat (2) @(negedge clk);
      #1;
      total++; if (stall !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffffffff", stall); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 2500; c++) begin
         tvalid = N'($urandom | $urandom);
         ordy   = ($urandom_range(0, 9) < 8);
         rst    = ($urandom_range(0, 399) == 0);
         case ($urandom_range(0, 4))
            0: fcount = '0;
            1: fcount = CW'($urandom_range(0, DEPTH));
            2: fcount = CW'(16321);
            3: fcount = CW'(16320);
            default: fcount = CW'(20000);
         endcase
         #1;
         total++; if (grant !== exp_grant || busy !== exp_busy) begin bad++; $display("FAIL rand_grant c=%0d got=%b/%b want=%b/%b", c, grant, busy, exp_grant, exp_busy); end
         total++; if (tready !== exp_tready) begin bad++; $display("FAIL rand_tready c=%0d got=%b want=%b", c, tready, exp_tready); end
         total++; if (ovalid !== exp_ov) begin bad++; $display("FAIL rand_ovalid c=%0d got=%b want=%b", c, ovalid, exp_ov); end
         total++; if (stall !== m_stall) begin bad++; $display("FAIL rand_stall c=%0d got=%0d want=%0d", c, stall, m_stall); end
         if (exp_ov) begin
            total++; if (odata !== exp_data) begin bad++; $display("FAIL rand_data c=%0d got=%h want=%h", c, odata[31:0], exp_data[31:0]); end
         end
         @(negedge clk);
      end
      rst = 1'b0;
      tvalid = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_bubbles();
      test_reset_mid();
      test_overflow_sat();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "time limit");
   end

endmodule
